// File: rtl/cgra_lsu_arbiter_if.sv
// Tile load/store bus and single memory port seen by the LSU arbiter.
// master: arbiter side (drives grants, rvalids, memory request); slave: tiles + memory.
interface cgra_lsu_arbiter_if #(
   parameter int NB_TILES = 16,
   parameter int DWIDTH   = 32
);
   logic [NB_TILES-1:0]        Tile_Req_I;
   logic [NB_TILES-1:0]        Tile_We_I;
   logic [NB_TILES*DWIDTH-1:0] Tile_Addr_I;
   logic [NB_TILES*DWIDTH-1:0] Tile_Wdata_I;
   logic [NB_TILES-1:0]        Tile_Grant_O;
   logic [NB_TILES-1:0]        Tile_Rvalid_O;
   logic [DWIDTH-1:0]          Tile_Rdata_O;
   logic                       Mem_Req_O;
   logic                       Mem_We_O;
   logic [DWIDTH-1:0]          Mem_Addr_O;
   logic [DWIDTH-1:0]          Mem_Wdata_O;
   logic [3:0]                 Mem_Be_O;
   logic                       Mem_Gnt_I;
   logic                       Mem_Rvalid_I;
   logic [DWIDTH-1:0]          Mem_Rdata_I;

   modport master (
      input  Tile_Req_I, Tile_We_I, Tile_Addr_I, Tile_Wdata_I,
      output Tile_Grant_O, Tile_Rvalid_O, Tile_Rdata_O,
      output Mem_Req_O, Mem_We_O, Mem_Addr_O, Mem_Wdata_O, Mem_Be_O,
      input  Mem_Gnt_I, Mem_Rvalid_I, Mem_Rdata_I
   );

   modport slave (
      output Tile_Req_I, Tile_We_I, Tile_Addr_I, Tile_Wdata_I,
      input  Tile_Grant_O, Tile_Rvalid_O, Tile_Rdata_O,
      input  Mem_Req_O, Mem_We_O, Mem_Addr_O, Mem_Wdata_O, Mem_Be_O,
      output Mem_Gnt_I, Mem_Rvalid_I, Mem_Rdata_I
   );
endinterface

// File: rtl/cgra_lsu_arbiter.sv
// Round-robin arbiter funnelling NB_TILES tile load/store requests into one memory port.
// Ports: Clk, Reset (async, active-low), bus (tile + memory signals), Busy_O.
module cgra_lsu_arbiter #(
   parameter int NB_TILES = 16,
   parameter int DWIDTH   = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   cgra_lsu_arbiter_if.master bus,
   output logic               Busy_O
);
   localparam int IW = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;
   localparam logic [IW:0] NT = (IW+1)'(NB_TILES);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t            state;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     idx;
   logic              we_q;
   logic              req_q;
   logic              busy_q;
   logic [DWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;

   logic              win_vld;
   logic [IW-1:0]     win_idx;
   logic [IW:0]       sum;

   // Scan downward so the candidate closest to rr_ptr is assigned last.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      sum     = '0;
      for (int k = NB_TILES - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         if (sum >= NT) sum = sum - NT;
         if (bus.Tile_Req_I[sum[IW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = sum[IW-1:0];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         idx     <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  idx     <= win_idx;
                  we_q    <= bus.Tile_We_I[win_idx];
                  addr_q  <= bus.Tile_Addr_I[win_idx*DWIDTH +: DWIDTH];
                  wdata_q <= bus.Tile_Wdata_I[win_idx*DWIDTH +: DWIDTH];
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (bus.Mem_Gnt_I) begin
                  rr_ptr <= (idx == IW'(NB_TILES - 1)) ? '0 : idx + 1'b1;
                  req_q  <= 1'b0;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (bus.Mem_Rvalid_I) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               req_q  <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Strobes follow the memory handshake in the same cycle.
   always_comb begin
      bus.Tile_Grant_O  = '0;
      bus.Tile_Rvalid_O = '0;
      for (int i = 0; i < NB_TILES; i++) begin
         if (idx == IW'(i)) begin
            bus.Tile_Grant_O[i]  = (state == REQ) && bus.Mem_Gnt_I;
            bus.Tile_Rvalid_O[i] = (state == WAIT) && bus.Mem_Rvalid_I && !we_q;
         end
      end
   end

   // Write enable is qualified by the request so it never lingers after a store.
   assign bus.Mem_Req_O    = req_q;
   assign bus.Mem_We_O     = req_q & we_q;
   assign bus.Mem_Addr_O   = addr_q;
   assign bus.Mem_Wdata_O  = wdata_q;
   assign bus.Mem_Be_O     = 4'hF;
   assign bus.Tile_Rdata_O = bus.Mem_Rdata_I;
   assign Busy_O           = busy_q;
endmodule

// File: tb/tb_cgra_lsu_arbiter.sv
// Scoreboard bench for cgra_lsu_arbiter: directed scenarios plus random traffic.
// A transaction-level reference model predicts grants, responses and port values.
module tb_cgra_lsu_arbiter;
   localparam int N  = 16;
   localparam int DW = 32;

   typedef struct {
      logic        rst;
      logic        busy;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } cyc_t;

   typedef struct {
      logic [N-1:0] vec;
      logic         we;
      logic [31:0]  addr;
      logic [31:0]  wdata;
   } gexp_t;

   typedef struct {
      logic [N-1:0] vec;
      logic [31:0]  data;
   } rexp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   cgra_lsu_arbiter_if #(.NB_TILES(N), .DWIDTH(DW)) bus ();

   cgra_lsu_arbiter #(.NB_TILES(N), .DWIDTH(DW)) dut (
      .Clk    (clk),
      .Reset  (rst_n),
      .bus    (bus),
      .Busy_O (busy)
   );

   int tests = 0;
   int fails = 0;

   cyc_t  cq[$];
   gexp_t gq[$];
   rexp_t rq[$];
   int    gorder[$];
   int    req_cycles = 0;

   // tile and memory stimulus
   bit          pend[N];
   bit          sticky[N];
   logic        t_we[N];
   logic [31:0] t_addr[N];
   logic [31:0] t_wd[N];
   logic        gnt_d, rv_d;
   logic [31:0] rd_d;

   // reference model: one open transaction at a time
   bit          m_act, m_gnt;
   int          m_tile, m_ptr;
   logic        m_we;
   logic [31:0] m_addr, m_wd;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst_v);
      cyc_t         c;
      logic [N-1:0] one;
      one = 1;
      @(posedge clk);
      #1;
      rst_n = rst_v;
      for (int i = 0; i < N; i++) begin
         bus.Tile_Req_I[i]            = pend[i];
         bus.Tile_We_I[i]             = t_we[i];
         bus.Tile_Addr_I[i*DW +: DW]  = t_addr[i];
         bus.Tile_Wdata_I[i*DW +: DW] = t_wd[i];
      end
      bus.Mem_Gnt_I    = gnt_d;
      bus.Mem_Rvalid_I = rv_d;
      bus.Mem_Rdata_I  = rd_d;
      c.rst   = !rst_v;
      c.rdata = rd_d;
      if (!rst_v) begin
         m_act   = 0;
         m_gnt   = 0;
         m_ptr   = 0;
         c.busy  = 0;
         c.req   = 0;
         c.we    = 0;
         c.addr  = 0;
         c.wdata = 0;
         cq.push_back(c);
         return;
      end
      c.busy  = m_act;
      c.req   = m_act && !m_gnt;
      c.we    = m_we;
      c.addr  = m_addr;
      c.wdata = m_wd;
      cq.push_back(c);
      if (m_act && !m_gnt && gnt_d)
         gq.push_back('{one << m_tile, m_we, m_addr, m_wd});
      if (m_act && m_gnt && rv_d && !m_we)
         rq.push_back('{one << m_tile, rd_d});
      if (!m_act) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (pend[j]) begin
               m_act  = 1;
               m_gnt  = 0;
               m_tile = j;
               m_we   = t_we[j];
               m_addr = t_addr[j];
               m_wd   = t_wd[j];
               break;
            end
         end
      end else if (!m_gnt) begin
         if (gnt_d) begin
            m_gnt = 1;
            m_ptr = (m_tile + 1) % N;
            if (!sticky[m_tile]) pend[m_tile] = 0;
         end
      end else if (rv_d) begin
         m_act = 0;
         m_gnt = 0;
      end
   endtask

   cyc_t  mc;
   gexp_t mg;
   rexp_t mr;

   always @(negedge clk) begin
      if (cq.size() > 0) begin
         mc = cq.pop_front();
         chk("busy", 32'(busy), 32'(mc.busy));
         chk("mem_req", 32'(bus.Mem_Req_O), 32'(mc.req));
         chk("mem_be", 32'(bus.Mem_Be_O), 32'hF);
         chk("tile_rdata", bus.Tile_Rdata_O, mc.rdata);
         if (bus.Mem_Req_O) req_cycles++;
         if (mc.req) begin
            chk("mem_we", 32'(bus.Mem_We_O), 32'(mc.we));
            chk("mem_addr", bus.Mem_Addr_O, mc.addr);
            chk("mem_wdata", bus.Mem_Wdata_O, mc.wdata);
         end
         if (mc.rst) chk("mem_we_rst", 32'(bus.Mem_We_O), 32'h0);
         if (bus.Tile_Grant_O !== '0) begin
            if (gq.size() == 0) begin
               chk("grant_unexpected", 32'(bus.Tile_Grant_O), 32'h0);
            end else begin
               mg = gq.pop_front();
               chk("grant_vec", 32'(bus.Tile_Grant_O), 32'(mg.vec));
               chk("grant_we", 32'(bus.Mem_We_O), 32'(mg.we));
               chk("grant_addr", bus.Mem_Addr_O, mg.addr);
               chk("grant_wdata", bus.Mem_Wdata_O, mg.wdata);
            end
            for (int i = 0; i < N; i++)
               if (bus.Tile_Grant_O[i]) gorder.push_back(i);
         end
         if (bus.Tile_Rvalid_O !== '0) begin
            if (rq.size() == 0) begin
               chk("rvalid_unexpected", 32'(bus.Tile_Rvalid_O), 32'h0);
            end else begin
               mr = rq.pop_front();
               chk("rvalid_vec", 32'(bus.Tile_Rvalid_O), 32'(mr.vec));
               chk("rvalid_data", bus.Tile_Rdata_O, mr.data);
            end
         end
      end
   end

   int rr_exp[4] = '{1, 5, 15, 1};
   int rc0;

   initial begin
      bus.Tile_Req_I   = '0;
      bus.Tile_We_I    = '0;
      bus.Tile_Addr_I  = '0;
      bus.Tile_Wdata_I = '0;
      bus.Mem_Gnt_I    = 1'b0;
      bus.Mem_Rvalid_I = 1'b0;
      bus.Mem_Rdata_I  = '0;
      for (int i = 0; i < N; i++) begin
         pend[i]   = 0;
         sticky[i] = 0;
         t_we[i]   = 0;
         t_addr[i] = 0;
         t_wd[i]   = 0;
      end
      gnt_d = 0;
      rv_d  = 0;
      rd_d  = 0;
      m_act = 0;
      m_gnt = 0;
      m_ptr = 0;
      m_tile = 0;
      m_we  = 0;
      m_addr = 0;
      m_wd  = 0;

      // reset, then spurious grant/response with no requests
      step(0);
      step(0);
      gnt_d = 1;
      rv_d  = 1;
      rd_d  = 32'hA5A5_5A5A;
      repeat (3) step(1);
      gnt_d = 0;
      rv_d  = 0;

      // single load, tile 3
      gorder.delete();
      pend[3]   = 1;
      t_we[3]   = 0;
      t_addr[3] = 32'h40;
      step(1);
      gnt_d = 1;
      step(1);
      gnt_d = 0;
      step(1);
      rv_d = 1;
      rd_d = 32'hDEAD_BEEF;
      step(1);
      rv_d = 0;
      step(1);
      chk("load_grant_count", 32'(gorder.size()), 32'd1);
      if (gorder.size() > 0) chk("load_grant_tile", 32'(gorder[0]), 32'd3);

      // store, tile 0 (pointer wraps past 3)
      pend[0]   = 1;
      t_we[0]   = 1;
      t_addr[0] = 32'h100;
      t_wd[0]   = 32'h1234_5678;
      step(1);
      gnt_d = 1;
      step(1);
      gnt_d = 0;
      step(1);
      rv_d = 1;
      rd_d = 32'hCAFE_F00D;
      step(1);
      rv_d = 0;
      step(1);

      // round-robin from reset: tiles 1, 5, 15 always requesting
      step(0);
      gorder.delete();
      foreach (rr_exp[i]) begin
         pend[rr_exp[i]]   = 1;
         sticky[rr_exp[i]] = 1;
         t_we[rr_exp[i]]   = 1'($urandom);
         t_addr[rr_exp[i]] = 32'h1000 + 32'(rr_exp[i] * 4);
         t_wd[rr_exp[i]]   = $urandom;
      end
      gnt_d = 1;
      rv_d  = 1;
      repeat (12) step(1);
      for (int i = 0; i < N; i++) begin
         pend[i]   = 0;
         sticky[i] = 0;
      end
      step(1);
      step(1);
      chk("rr_count", 32'(gorder.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (gorder.size() > i) chk("rr_order", 32'(gorder[i]), 32'(rr_exp[i]));

      // grant backpressure; the tile drops and changes its address after selection
      gnt_d = 0;
      rv_d  = 0;
      pend[7]   = 1;
      t_we[7]   = 1;
      t_addr[7] = 32'h7770;
      t_wd[7]   = 32'h0BAD_F00D;
      step(1);
      rc0 = req_cycles;
      pend[7]   = 0;
      t_addr[7] = 32'hFFFF_0000;
      t_wd[7]   = 32'h1111_2222;
      repeat (5) step(1);
      gnt_d = 1;
      step(1);
      gnt_d = 0;
      step(1);
      rv_d = 1;
      step(1);
      rv_d = 0;
      step(1);
      chk("bp_req_cycles", 32'(req_cycles - rc0), 32'd6);

      // reset while waiting; the late response must be ignored
      pend[2]   = 1;
      t_we[2]   = 0;
      t_addr[2] = 32'h200;
      step(1);
      gnt_d = 1;
      step(1);
      gnt_d = 0;
      step(1);
      step(0);
      rv_d = 1;
      rd_d = 32'h5555_AAAA;
      step(1);
      rv_d = 0;
      gorder.delete();
      pend[5] = 1;
      pend[1] = 1;
      gnt_d = 1;
      rv_d  = 1;
      repeat (3) step(1);
      step(1);
      chk("post_reset_first", gorder.size() > 0 ? 32'(gorder[0]) : 32'hFFFF, 32'd1);
      repeat (4) step(1);
      pend[1] = 0;
      pend[5] = 0;

      // random traffic with spurious handshakes and occasional resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && !(m_act && m_tile == i) && $urandom_range(15) == 0) begin
               pend[i]   = 1;
               t_we[i]   = 1'($urandom);
               t_addr[i] = $urandom;
               t_wd[i]   = $urandom;
            end
         end
         if (m_act && !m_gnt && $urandom_range(7) == 0) begin
            pend[m_tile]   = 0;
            t_addr[m_tile] = $urandom;
            t_wd[m_tile]   = $urandom;
         end
         gnt_d = ($urandom_range(2) != 0);
         rv_d  = ($urandom_range(2) == 0);
         rd_d  = $urandom;
         step($urandom_range(399) != 0);
      end

      for (int i = 0; i < N; i++) pend[i] = 0;
      gnt_d = 1;
      rv_d  = 1;
      repeat (4) step(1);
      step(1);
      chk("grants_left", 32'(gq.size()), 32'd0);
      chk("rvalids_left", 32'(rq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
